// File: rtl/johnson_gray_sequencer.sv
// rtl/johnson_gray_sequencer.sv - Johnson ring sequencer with Gray output, gapped runs, load and abort
module johnson_gray_sequencer #(
    parameter int GAP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dir,
    input  logic [3:0] steps,
    input  logic       abort,
    input  logic       load,
    input  logic [3:0] ld_value,
    output logic [3:0] johnson,
    output logic [2:0] gray,
    output logic       busy,
    output logic       step_valid,
    output logic       wrap,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STEP
    } state_t;

    localparam logic [3:0] GAP_RELOAD = 4'(GAP - 1);

    state_t     state;
    logic [3:0] gap_cnt;
    logic [3:0] remaining;
    logic       dir_q;
    logic [3:0] johnson_next;

    function automatic logic is_legal(input logic [3:0] j);
        case (j)
            4'b0000, 4'b0001, 4'b0011, 4'b0111,
            4'b1111, 4'b1110, 4'b1100, 4'b1000: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    assign johnson_next = dir_q ? {~johnson[0], johnson[3:1]}
                                : {johnson[2:0], ~johnson[3]};

    // Gray is decoded straight from the register so it can never lag johnson.
    assign gray = {johnson[3], johnson[1], johnson[2] ^ johnson[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            johnson    <= 4'b0000;
            gap_cnt    <= 4'd0;
            remaining  <= 4'd0;
            dir_q      <= 1'b0;
            busy       <= 1'b0;
            step_valid <= 1'b0;
            wrap       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            step_valid <= 1'b0;
            wrap       <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        if (is_legal(ld_value)) begin
                            johnson <= ld_value;
                            err     <= 1'b0;
                        end else begin
                            johnson <= 4'b0000;
                            err     <= 1'b1;
                        end
                    end else if (start) begin
                        if (steps != 4'd0) begin
                            dir_q     <= dir;
                            remaining <= steps;
                            gap_cnt   <= GAP_RELOAD;
                            state     <= WAIT;
                            busy      <= 1'b1;
                            err       <= 1'b0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (gap_cnt == 4'd0) begin
                        state <= STEP;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                STEP: begin
                    // Abort wins over the step scheduled for this cycle.
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        johnson    <= johnson_next;
                        step_valid <= 1'b1;
                        wrap       <= (johnson_next == 4'b0000);
                        remaining  <= remaining - 4'd1;
                        if (remaining == 4'd1) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            gap_cnt <= GAP_RELOAD;
                            state   <= WAIT;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_johnson_gray_sequencer.sv
// tb/tb_johnson_gray_sequencer.sv - directed and randomized checks against a ring-index model
module tb_johnson_gray_sequencer;

    localparam int GAP = 4;
    localparam int PER = GAP + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       dir;
    logic [3:0] steps;
    logic       abort;
    logic       load;
    logic [3:0] ld_value;
    logic [3:0] johnson;
    logic [2:0] gray;
    logic       busy;
    logic       step_valid;
    logic       wrap;
    logic       done;
    logic       err;

    johnson_gray_sequencer #(.GAP(GAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dir        (dir),
        .steps      (steps),
        .abort      (abort),
        .load       (load),
        .ld_value   (ld_value),
        .johnson    (johnson),
        .gray       (gray),
        .busy       (busy),
        .step_valid (step_valid),
        .wrap       (wrap),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    logic [3:0] ring [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                             4'b1111, 4'b1110, 4'b1100, 4'b1000};

    int   tests = 0;
    int   fails = 0;
    int   m_idx = 0;
    logic m_err = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic b, input logic sv,
                           input logic wr, input logic dn);
        chk({tag, ".johnson"}, 8'(johnson), 8'(ring[m_idx]));
        chk({tag, ".gray"}, 8'(gray), 8'(m_idx ^ (m_idx >> 1)));
        chk({tag, ".busy"}, 8'(busy), 8'(b));
        chk({tag, ".step_valid"}, 8'(step_valid), 8'(sv));
        chk({tag, ".wrap"}, 8'(wrap), 8'(wr));
        chk({tag, ".done"}, 8'(done), 8'(dn));
        chk({tag, ".err"}, 8'(err), 8'(m_err));
    endtask

    task automatic do_load(input logic [3:0] v, input logic with_start);
        int found = -1;
        load = 1'b1; ld_value = v; start = with_start; steps = 4'd5;
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        for (int i = 0; i < 8; i++) if (ring[i] == v) found = i;
        if (found < 0) begin m_idx = 0; m_err = 1'b1; end
        else begin m_idx = found; m_err = 1'b0; end
        chk_all("load", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_all("load_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run(input logic d, input int n, input int abort_step, input int rst_step);
        start = 1'b1; dir = d; steps = 4'(n);
        @(negedge clk);
        start = 1'b0; dir = 1'($urandom); steps = 4'($urandom);
        if (n == 0) begin
            chk_all("zero", 1'b0, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            chk_all("zero_after", 1'b0, 1'b0, 1'b0, 1'b0);
            return;
        end
        m_err = 1'b0;
        chk_all("start", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= n * PER; k++) begin
            if (k == 2) begin load = 1'b1; ld_value = 4'b0101; start = 1'b1; end
            if (k == 3) begin load = 1'b0; start = 1'b0; end
            if (abort_step > 0 && k == abort_step * PER) abort = 1'b1;
            @(negedge clk);
            if (abort) begin
                abort = 1'b0;
                chk_all("abort", 1'b0, 1'b0, 1'b0, 1'b0);
                @(negedge clk);
                chk_all("abort_idle", 1'b0, 1'b0, 1'b0, 1'b0);
                return;
            end
            if (k % PER == 0) begin
                logic last;
                last  = (k == n * PER);
                m_idx = d ? (m_idx + 7) % 8 : (m_idx + 1) % 8;
                chk_all("step", !last, 1'b1, m_idx == 0, last);
                if (rst_step > 0 && k / PER == rst_step) begin
                    #2 rst = 1'b1;
                    #1 m_idx = 0; m_err = 1'b0;
                    chk_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
                    @(negedge clk);
                    rst = 1'b0;
                    chk_all("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
                    return;
                end
            end else begin
                chk_all("gap", 1'b1, 1'b0, 1'b0, 1'b0);
            end
        end
        @(negedge clk);
        chk_all("post_run", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dir = 1'b0; steps = 4'd0;
        abort = 1'b0; load = 1'b0; ld_value = 4'd0;
        @(negedge clk);
        @(negedge clk);
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        run(1'b0, 8, 0, 0);
        do_load(4'b1100, 1'b0);
        run(1'b1, 3, 0, 0);
        do_load(4'b0101, 1'b0);
        do_load(4'b0011, 1'b0);
        do_load(4'b0000, 1'b0);
        run(1'b0, 10, 4, 0);

        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_all("idle_abort", 1'b0, 1'b0, 1'b0, 1'b0);

        run(1'b0, 0, 0, 0);
        do_load(4'b0111, 1'b1);
        run(1'b0, 5, 0, 2);
        run(1'b0, 1, 0, 0);

        for (int r = 0; r < 12; r++) begin
            int n;
            int ab;
            if ($urandom_range(0, 1) == 1) do_load(4'($urandom), 1'b0);
            n  = $urandom_range(0, 15);
            ab = (n > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n) : 0;
            run(1'($urandom), n, ab, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/johnson_gray_sequencer.md
Name: johnson_gray_sequencer

Overview:
- Sequences a 4-bit Johnson counter register through its 8-state ring and presents the matching 3-bit Gray code.
- Runs a requested number of steps up or down, spaced by a programmable gap.
- Supports a direct load with illegal-code detection and recovery, plus abort.
- Sits in front of the Johnson-to-Gray conversion logic as its controller and stimulus source.

Parameters:
- GAP, 4: idle cycles between successive steps; legal range 1..15; 4-bit gap counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  starts a run; sampled only in IDLE.
- dir  input  1  direction latched at start: 0 = up, 1 = down.
- steps  input  4  number of steps in the run (0..15); latched at start.
- abort  input  1  terminates a run from WAIT or STEP.
- load  input  1  loads ld_value; sampled only in IDLE.
- ld_value  input  4  Johnson code to load.
- johnson  output  4  current Johnson register.
- gray  output  3  Gray code of johnson.
- busy  output  1  high while in WAIT or STEP.
- step_valid  output  1  one-cycle pulse; johnson and gray hold the new value in that cycle.
- wrap  output  1  one-cycle pulse with step_valid when the new johnson is 0000.
- done  output  1  one-cycle pulse at run completion.
- err  output  1  sticky illegal-load flag.

Behaviour:
- Reset (async): johnson=0000, gray=000, busy=0, step_valid=0, wrap=0, done=0, err=0, state=IDLE, gap counter=0, remaining=0.
- Legal Johnson codes: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000.
- gray is a pure function of the johnson register: g[2]=j[3], g[1]=j[1], g[0]=j[2]^j[0]. It never lags johnson.
- Up step: johnson <= {j[2:0], ~j[3]}.
- Down step: johnson <= {~j[0], j[3:1]}.
- FSM states are IDLE, WAIT and STEP.
- IDLE, priority load > start:
  - Load with a legal ld_value: johnson <= ld_value, err <= 0.
  - Load with an illegal ld_value: johnson <= 0000, err <= 1.
  - start with steps != 0: latch dir and steps into remaining, load gap counter with GAP-1, go to WAIT, err <= 0.
  - start with steps == 0: done=1 for one cycle, johnson unchanged, no step_valid, stay in IDLE.
- WAIT: decrement the gap counter. When it reaches 0, the next state is STEP.
- STEP (1 cycle):
  - johnson advances by one step.
  - step_valid (and wrap if applicable) is registered together with the new value.
  - remaining decrements.
  - If remaining was 1: done=1 and busy=0 coincide with this step_valid; return to IDLE.
  - Otherwise reload the gap counter with GAP-1 and return to WAIT.
- Timing:
  - First step_valid occurs GAP+1 cycles after the edge that samples start.
  - Subsequent step_valid pulses occur every GAP+1 cycles.
  - Total run length is steps*(GAP+1) cycles.
- abort in WAIT or STEP:
  - Next state is IDLE. Abort beats a same-cycle STEP: no step is taken.
  - johnson keeps its value; step_valid, wrap and done stay 0; busy=0 next cycle.
- abort in IDLE has no effect.
- start and load while busy are ignored.
- Wrap-around is continuous: an up step from 1000 gives 0000 with wrap=1; a down step from 0001 gives 0000 with wrap=1.
- Reset mid-run returns immediately to the reset values; no done pulse.
- Simultaneous load and start in IDLE: the load is performed and start is ignored.

Test Plan:
- Reset, then start with dir=0, steps=8, GAP=4 -> step_valid every 5 cycles; johnson sequence 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; gray sequence 001, 011, 010, 110, 111, 101, 100, 000; wrap and done on the 8th step; busy low afterwards.
- load 1100, then start with dir=1, steps=3 -> johnson 1110, 1111, 0111; gray 111, 110, 010; done with the 3rd step; wrap never.
- load 0101 (illegal) -> johnson=0000, gray=000, err=1. Then load 0011 -> johnson=0011, err=0.
- start with dir=0, steps=10 from 0000, abort asserted in the cycle the FSM is in STEP for the 4th step -> johnson stays 0111, no 4th step_valid, no done, busy=0 next cycle.
- start with steps=0 -> done pulse one cycle later, no step_valid, johnson unchanged. Then load and start in the same IDLE cycle -> only the load takes effect, busy stays 0.
- Assert rst mid-run after the 2nd step -> all outputs return to reset values asynchronously; a later start with steps=1 yields johnson 0001 after GAP+1 cycles.
